// File: rtl/gonso_wb_pkg.sv
// Shared types and constants for the gonso Wishbone initiator and its wait timer.
// Also holds the addresses of the gonso register block on the user-project bus.
package gonso_wb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned SEL_W  = 4;

  localparam logic [ADDR_W-1:0] GONSO_REG_ADDR       = 32'h3003_0004;
  localparam logic [ADDR_W-1:0] GONSO_PLUS_REG_ADDR  = 32'h3003_0008;
  localparam logic [ADDR_W-1:0] GONSO_COLOR_REG_ADDR = 32'h3003_000C;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  // Width of a counter that must hold 0..t; a disabled timeout still gets one bit.
  function automatic int unsigned cnt_width(input int unsigned t);
    return (t == 0) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/gonso_wb_timer.sv
// Clearable bus wait counter with terminal-count flag.
// The flag rises when the counter reaches TIMEOUT_CYCLES-1; it never rises when TIMEOUT_CYCLES is 0.
module gonso_wb_timer
  import gonso_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int unsigned W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [W-1:0] TC_VAL = W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic ENABLED = (TIMEOUT_CYCLES != 0);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc_o = ENABLED && (cnt_q == TC_VAL);

  // Holding at terminal count keeps the counter from wrapping while the flag is consumed.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && ENABLED && !tc_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gonso_wb_initiator.sv
// Single-outstanding Wishbone classic initiator: request stream in, one bus cycle, response stream out.
// All outputs are registered; a bounded wait converts a missing ack into an error response.
module gonso_wb_initiator
  import gonso_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [SEL_W-1:0]  req_sel,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [DATA_W-1:0] wbm_dat_o,
  output logic [SEL_W-1:0]  wbm_sel_o,
  input  logic [DATA_W-1:0] wbm_dat_i,
  input  logic              wbm_ack_i,
  output logic [7:0]        timeout_count
);

  wb_state_e         state_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_data_q;
  logic              resp_err_q;
  logic              cyc_q;
  logic              we_q;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] dat_q;
  logic [SEL_W-1:0]  sel_q;
  logic [7:0]        tcnt_q;
  logic [7:0]        tcnt_d;
  logic              timer_tc;

  gonso_wb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr_i(state_q != BUS),
    .inc_i(!wbm_ack_i),
    .tc_o (timer_tc)
  );

  assign tcnt_d = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      tcnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            we_q        <= req_we;
            adr_q       <= req_addr;
            dat_q       <= req_data;
            sel_q       <= req_sel;
            cyc_q       <= 1'b1;
            req_ready_q <= 1'b0;
            state_q     <= BUS;
          end
        end
        BUS: begin
          // Ack is tested first so it wins over a coincident terminal count.
          if (wbm_ack_i) begin
            resp_data_q  <= we_q ? '0 : wbm_dat_i;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b1;
            cyc_q        <= 1'b0;
            state_q      <= RESP;
          end else if (timer_tc) begin
            resp_data_q  <= '0;
            resp_err_q   <= 1'b1;
            resp_valid_q <= 1'b1;
            cyc_q        <= 1'b0;
            tcnt_q       <= tcnt_d;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_data     = resp_data_q;
  assign resp_err      = resp_err_q;
  assign wbm_cyc_o     = cyc_q;
  assign wbm_stb_o     = cyc_q;
  assign wbm_we_o      = we_q;
  assign wbm_adr_o     = adr_q;
  assign wbm_dat_o     = dat_q;
  assign wbm_sel_o     = sel_q;
  assign timeout_count = tcnt_q;

endmodule

// File: tb/tb_gonso_wb_initiator.sv
// Self-checking bench: a gonso-like responder model, a response scoreboard and one task per scenario.
// Latency is counted in rising edges starting with the edge that accepts the request.
module tb_gonso_wb_initiator;
  import gonso_wb_pkg::*;

  localparam int unsigned TO = 4;
  localparam logic [31:0] NOADDR = 32'h3004_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_data;
  logic [3:0]  req_sel;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_data;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic [7:0]  timeout_count;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t sb_q[$];
  int    checks = 0;
  int    errors = 0;
  time   acc_time;

  // Responder model: registered ack one cycle after stb, byte-lane writes, reset with rst.
  logic [31:0] regs [3];
  logic        rsp_ack_q;
  logic [31:0] rsp_dat_q;
  logic        force_ack;
  logic [31:0] force_data;
  int          rsp_idx;
  logic [31:0] rsp_nv;

  function automatic int reg_idx(input logic [31:0] a);
    if (a == GONSO_REG_ADDR) return 0;
    if (a == GONSO_PLUS_REG_ADDR) return 1;
    if (a == GONSO_COLOR_REG_ADDR) return 2;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      rsp_ack_q <= 1'b0;
      rsp_dat_q <= '0;
      for (int i = 0; i < 3; i++) regs[i] <= '0;
    end else begin
      rsp_ack_q <= 1'b0;
      rsp_idx = reg_idx(wbm_adr_o);
      if (wbm_cyc_o && wbm_stb_o && !rsp_ack_q && rsp_idx >= 0) begin
        rsp_ack_q <= 1'b1;
        rsp_dat_q <= regs[rsp_idx];
        if (wbm_we_o) begin
          rsp_nv = regs[rsp_idx];
          for (int b = 0; b < 4; b++)
            if (wbm_sel_o[b]) rsp_nv[8*b +: 8] = wbm_dat_o[8*b +: 8];
          regs[rsp_idx] <= rsp_nv;
        end
      end
    end
  end

  assign wbm_ack_i = rsp_ack_q | force_ack;
  assign wbm_dat_i = force_ack ? force_data : rsp_dat_q;

  gonso_wb_initiator #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_sel      (req_sel),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_err     (resp_err),
    .wbm_cyc_o    (wbm_cyc_o),
    .wbm_stb_o    (wbm_stb_o),
    .wbm_we_o     (wbm_we_o),
    .wbm_adr_o    (wbm_adr_o),
    .wbm_dat_o    (wbm_dat_o),
    .wbm_sel_o    (wbm_sel_o),
    .wbm_dat_i    (wbm_dat_i),
    .wbm_ack_i    (wbm_ack_i),
    .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Present a request until accepted; returns 1ps after the accepting edge.
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] exp_d, input logic exp_e,
                       input bit push);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_data = d; req_sel = s;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (req_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL issue_accept: req_ready got %b required 1 within 50 cycles", req_ready);
    end
    @(posedge clk);
    acc_time = $time;
    #1;
    req_valid = 1'b0;
    if (push) sb_q.push_back('{data: exp_d, err: exp_e});
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 64) begin
      @(posedge clk); #1; lat++;
    end
    if (resp_valid !== 1'b1) begin
      checks++; errors++;
      $display("FAIL resp_wait: resp_valid got %b required 1 within 64 cycles", resp_valid);
    end
  endtask

  task automatic test_reset();
    int n = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, resp_valid, resp_err, req_ready} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: cyc/stb/we/rvalid/rerr/rready got %b required 000000",
               {wbm_cyc_o, wbm_stb_o, wbm_we_o, resp_valid, resp_err, req_ready});
    end
    checks++;
    if ({wbm_adr_o, wbm_dat_o, wbm_sel_o, resp_data, timeout_count} !== '0) begin
      errors++;
      $display("FAIL reset_data: adr %h dat %h sel %h rdata %h tcnt %0d required all 0",
               wbm_adr_o, wbm_dat_o, wbm_sel_o, resp_data, timeout_count);
    end
    rst = 1'b0;
    while (req_ready !== 1'b1 && n < 5) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: req_ready got %b required 1 in IDLE", req_ready);
    end
  endtask

  task automatic test_write_read();
    int lat;
    resp_t e;
    issue(1'b1, GONSO_REG_ADDR, 32'h000A_BCDE, 4'hF, 32'h0, 1'b0, 1'b1);
    wait_resp(lat);
    e = sb_q.pop_front();
    checks++;
    if ({resp_data, resp_err} !== {e.data, e.err}) begin
      errors++;
      $display("FAIL wr_resp: data %h err %b required %h %b", resp_data, resp_err, e.data, e.err);
    end
    @(posedge clk); #1;
    issue(1'b0, GONSO_REG_ADDR, 32'h0, 4'hF, 32'h000A_BCDE, 1'b0, 1'b1);
    wait_resp(lat);
    e = sb_q.pop_front();
    checks++;
    if ({resp_data, resp_err} !== {e.data, e.err}) begin
      errors++;
      $display("FAIL rd_resp: data %h err %b required %h %b", resp_data, resp_err, e.data, e.err);
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL rd_latency: got %0d cycles required 3", lat);
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_handshake: resp_valid got %b required 0 after accept", resp_valid);
    end
  endtask

  task automatic test_partial_write();
    int lat;
    resp_t e;
    // Overwrite GONSO_REG: the responder returns its old contents, which must not leak into resp_data.
    issue(1'b1, GONSO_REG_ADDR, 32'h0001_1111, 4'hF, 32'h0, 1'b0, 1'b1);
    issue_and_check_dummy();
    issue(1'b1, GONSO_COLOR_REG_ADDR, 32'hFFFF_FF5A, 4'h1, 32'h0, 1'b0, 1'b1);
    wait_resp(lat);
    e = sb_q.pop_front();
    checks++;
    if ({resp_data, resp_err} !== {e.data, e.err}) begin
      errors++;
      $display("FAIL pw_wr_resp: data %h err %b required %h %b", resp_data, resp_err, e.data, e.err);
    end
    @(posedge clk); #1;
    issue(1'b0, GONSO_COLOR_REG_ADDR, 32'h0, 4'hF, 32'h0000_005A, 1'b0, 1'b1);
    wait_resp(lat);
    e = sb_q.pop_front();
    checks++;
    if ({resp_data, resp_err} !== {e.data, e.err}) begin
      errors++;
      $display("FAIL pw_rd_resp: data %h err %b required %h %b", resp_data, resp_err, e.data, e.err);
    end
    @(posedge clk); #1;
  endtask

  task automatic issue_and_check_dummy();
    int lat;
    resp_t e;
    wait_resp(lat);
    e = sb_q.pop_front();
    checks++;
    if ({resp_data, resp_err} !== {e.data, e.err}) begin
      errors++;
      $display("FAIL ow_wr_resp: data %h err %b required %h %b", resp_data, resp_err, e.data, e.err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int cnt = 0;
    resp_t e;
    issue(1'b0, NOADDR, 32'h0, 4'hF, 32'h0, 1'b1, 1'b1);
    while (wbm_cyc_o === 1'b1 && cnt < 50) begin
      cnt++; @(posedge clk); #1;
    end
    checks++;
    if (cnt != TO) begin
      errors++;
      $display("FAIL to_cyc_len: cyc high %0d cycles required %0d", cnt, TO);
    end
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL to_rvalid: resp_valid got %b required 1 after cyc drops", resp_valid);
    end
    e = sb_q.pop_front();
    checks++;
    if ({resp_data, resp_err} !== {e.data, e.err}) begin
      errors++;
      $display("FAIL to_resp: data %h err %b required %h %b", resp_data, resp_err, e.data, e.err);
    end
    checks++;
    if (timeout_count !== 8'd1) begin
      errors++;
      $display("FAIL to_count: timeout_count got %0d required 1", timeout_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat;
    resp_t e;
    logic [31:0] held_d;
    logic held_e;
    resp_ready = 1'b0;
    issue(1'b0, GONSO_REG_ADDR, 32'h0, 4'hF, 32'h0001_1111, 1'b0, 1'b1);
    wait_resp(lat);
    e = sb_q.pop_front();
    checks++;
    if ({resp_data, resp_err} !== {e.data, e.err}) begin
      errors++;
      $display("FAIL bp_resp: data %h err %b required %h %b", resp_data, resp_err, e.data, e.err);
    end
    held_d = e.data;
    held_e = e.err;
    req_valid = 1'b1; req_we = 1'b1; req_addr = GONSO_PLUS_REG_ADDR; req_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({resp_valid, resp_data, resp_err, req_ready, wbm_cyc_o} !== {1'b1, held_d, held_e, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: rvalid %b data %h err %b rready %b cyc %b required 1 %h %b 0 0",
                 i, resp_valid, resp_data, resp_err, req_ready, wbm_cyc_o, held_d, held_e);
      end
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release: rvalid %b rready %b required 0 1", resp_valid, req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (wbm_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_ignored: cyc got %b required 0 (held request must be ignored)", wbm_cyc_o);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    resp_t e;
    time t0;
    issue(1'b0, GONSO_REG_ADDR, 32'h0, 4'hF, 32'h0001_1111, 1'b0, 1'b1);
    t0 = acc_time;
    wait_resp(lat);
    e = sb_q.pop_front();
    checks++;
    if ({resp_data, resp_err} !== {e.data, e.err}) begin
      errors++;
      $display("FAIL b2b_resp0: data %h err %b required %h %b", resp_data, resp_err, e.data, e.err);
    end
    @(posedge clk); #1;
    issue(1'b0, GONSO_COLOR_REG_ADDR, 32'h0, 4'hF, 32'h0000_005A, 1'b0, 1'b1);
    checks++;
    if (acc_time - t0 != 40) begin
      errors++;
      $display("FAIL b2b_period: accept spacing %0t required 40 (4 cycles)", acc_time - t0);
    end
    wait_resp(lat);
    e = sb_q.pop_front();
    checks++;
    if ({resp_data, resp_err} !== {e.data, e.err}) begin
      errors++;
      $display("FAIL b2b_resp1: data %h err %b required %h %b", resp_data, resp_err, e.data, e.err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ack_at_timeout();
    int lat;
    resp_t e;
    force_data = 32'hCAFE_F00D;
    issue(1'b0, NOADDR, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    force_ack = 1'b1;
    @(posedge clk); #1;
    force_ack = 1'b0;
    wait_resp(lat);
    e = sb_q.pop_front();
    checks++;
    if ({resp_data, resp_err} !== {e.data, e.err}) begin
      errors++;
      $display("FAIL tc_ack_resp: data %h err %b required %h %b", resp_data, resp_err, e.data, e.err);
    end
    checks++;
    if (timeout_count !== 8'd1) begin
      errors++;
      $display("FAIL tc_ack_count: timeout_count got %0d required 1", timeout_count);
    end
    @(posedge clk); #1;
    force_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({resp_valid, wbm_cyc_o, req_ready} !== 3'b001) begin
        errors++;
        $display("FAIL stray_ack[%0d]: rvalid %b cyc %b rready %b required 0 0 1",
                 i, resp_valid, wbm_cyc_o, req_ready);
      end
    end
    force_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    resp_t e;
    bit seen = 1'b0;
    issue(1'b0, NOADDR, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({wbm_cyc_o, wbm_stb_o, resp_valid, timeout_count} !== 11'b0) begin
      errors++;
      $display("FAIL mid_rst: cyc %b stb %b rvalid %b tcnt %0d required 0 0 0 0",
               wbm_cyc_o, wbm_stb_o, resp_valid, timeout_count);
    end
    rst = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (resp_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL mid_rst_discard: resp_valid got 1 required 0 after reset");
    end
    issue(1'b1, GONSO_PLUS_REG_ADDR, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 1'b1);
    wait_resp(lat);
    e = sb_q.pop_front();
    checks++;
    if ({resp_data, resp_err} !== {e.data, e.err}) begin
      errors++;
      $display("FAIL mid_wr_resp: data %h err %b required %h %b", resp_data, resp_err, e.data, e.err);
    end
    @(posedge clk); #1;
    issue(1'b0, GONSO_PLUS_REG_ADDR, 32'h0, 4'hF, 32'h1234_5678, 1'b0, 1'b1);
    wait_resp(lat);
    e = sb_q.pop_front();
    checks++;
    if ({resp_data, resp_err} !== {e.data, e.err} || lat != 3) begin
      errors++;
      $display("FAIL mid_rd_resp: data %h err %b lat %0d required %h %b 3",
               resp_data, resp_err, lat, e.data, e.err);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0; req_sel = '0;
    resp_ready = 1'b1;
    force_ack = 1'b0; force_data = '0;
    test_reset();
    test_write_read();
    test_partial_write();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_ack_at_timeout();
    test_reset_mid();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d responses outstanding required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gonso_wb_initiator.md
# gonso_wb_initiator

Single-outstanding Wishbone classic-cycle initiator that converts a local valid/ready request stream into Wishbone read/write cycles and returns each result on a valid/ready response stream. It drives the responder side of the user-project Wishbone bus, the gonso register block at 0x3003_0004..0x3003_000C. It lets on-chip logic such as self-test or a sequencer access those registers without the management core. A bounded-wait timer guarantees forward progress when no responder acknowledges.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles `cyc` is held awaiting `ack`. A value of 0 disables the timeout.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  1  client request present.
- req_ready  output  1  block can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  32  byte address.
- req_data  input  32  write data.
- req_sel  input  4  byte lane enables.
- resp_valid  output  1  response present.
- resp_ready  input  1  client accepts the response.
- resp_data  output  32  read data; 0 for writes and for timeouts.
- resp_err  output  1  1 = transaction timed out.
- wbm_cyc_o, wbm_stb_o  output  1 each  bus cycle and strobe; always equal.
- wbm_we_o  output  1  write enable.
- wbm_adr_o  output  32  address.
- wbm_dat_o  output  32  write data.
- wbm_sel_o  output  4  byte select.
- wbm_dat_i  input  32  read data.
- wbm_ack_i  input  1  acknowledge.
- timeout_count  output  8  saturating count of timed-out transactions.

## Operation
- The FSM has three states: IDLE, BUS and RESP. It enters IDLE on reset.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid && req_ready`, latch `we`, `addr`, `data` and `sel` into the bus output registers and go to BUS.
- **BUS**
  - `cyc` = `stb` = 1. Bus outputs stay stable for the whole cycle.
  - The wait counter starts at 0 on entry and increments each cycle `ack` is low.
  - On `ack` sampled high: capture `wbm_dat_i` into `resp_data` (0 if `we`), set `resp_err` = 0 and go to RESP.
  - Else, if TIMEOUT_CYCLES ≠ 0 and counter == TIMEOUT_CYCLES−1: set `resp_data` = 0, `resp_err` = 1, increment `timeout_count` (saturating at 255) and go to RESP.
- **RESP**
  - `resp_valid` = 1 and `cyc` = `stb` = 0.
  - The response outputs hold until `resp_ready`, then go to IDLE.
- `req_ready` is 0 in BUS and RESP. `resp_valid` is 0 in IDLE and BUS.
- An `ack` arriving in IDLE or RESP (stray ack) is ignored and has no effect.
- `ack` and timeout in the same cycle: `ack` wins and `resp_err` = 0.
- Reset values:
  - `cyc`, `stb`, `we`, `resp_valid`, `resp_err` = 0.
  - `req_ready` = 0 during the reset cycle, then 1 in IDLE.
  - `adr`, `dat_o`, `sel`, `resp_data` = 0.
  - `timeout_count` = 0.
- Reset mid-transaction: `cyc`/`stb` drop at the reset edge and any pending response is discarded (no `resp_valid`).

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Request accepted at edge N → `cyc`/`stb` high from N+1.
- `ack` sampled high at edge M → `cyc`/`stb` low and `resp_valid` high from M+1.
- Against the gonso responder, which registers `ack` one cycle after `stb`:
  - Request accept to `resp_valid` takes 3 cycles.
  - `cyc` stays high exactly 2 cycles, so the responder never sees a second access.
- Timeout: `cyc` is high for exactly TIMEOUT_CYCLES cycles, then `resp_valid` rises.
- Back-to-back throughput is 1 transaction per 4 cycles with zero-wait `resp_ready` against the gonso responder: RESP → IDLE → accept.

## Structure
- Shared package `gonso_wb_pkg` holds:
  - the FSM state enum (IDLE, BUS, RESP);
  - the register address constants GONSO_REG_ADDR 0x3003_0004, GONSO_PLUS_REG_ADDR 0x3003_0008 and GONSO_COLOR_REG_ADDR 0x3003_000C;
  - the data, address and sel widths.
- One sub-module, `gonso_wb_timer`. It provides the clearable wait counter with a terminal-count flag, parameterised by TIMEOUT_CYCLES, with width clog2(TIMEOUT_CYCLES+1).

## Test plan
- **Write then read:** write 0x30030004, data 0x000ABCDE, sel 0xF; then read 0x30030004. Required: `resp_err` = 0 on both, and the read returns `resp_data` 0x000ABCDE with 3-cycle latency.
- **Partial write:** write 0x3003000C, data 0xFFFFFF5A, sel 0x1. A following read returns 0x0000005A.
- **Timeout:** read 0x30040000 (no responder) with TIMEOUT_CYCLES = 4. Required: `cyc` high exactly 4 cycles, then `resp_valid` with `resp_err` = 1, `resp_data` 0 and `timeout_count` = 1.
- **Response backpressure:** hold `resp_ready` = 0 for 5 cycles after `resp_valid`. Required: `resp_data`/`resp_err` stable, `req_ready` = 0, and `req_valid` ignored. Release → IDLE one cycle later.
- **Ack at the timeout edge:** `ack` asserted on the same cycle as terminal count. Required: `resp_err` = 0 and the data is captured. A stray `ack` while in IDLE causes no `resp_valid`.
- **Reset mid-operation:** assert `rst` while in BUS. Required: `cyc`/`stb` = 0 after the edge, no `resp_valid`, `timeout_count` = 0. The next request completes normally.
